riscv_zero_fetch: RTL and testbench

Instruction fetch stage. It sits directly upstream of the decode stage and owns the architectural fetch PC. It issues word reads to instruction memory over a req/ack handshake with at most one request outstanding. Each fetched instruction is registered onto inst_data/pc_out for decode; cycles with no instruction carry a NOP bubble. It absorbs stalls from downstream and redirects (branch/jump) from execute.

---
 rtl/riscv_zero_fetch.sv | 156 +++++++++++++++
 tb/tb_riscv_zero_fetch.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_zero_fetch.sv
// Instruction fetch stage: owns the fetch PC, issues one-outstanding word reads
// to instruction memory and registers fetched instructions (or NOP bubbles) for decode.
module riscv_zero_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst_data,
  output logic [63:0] pc_out,
  output logic        inst_valid
);

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;

  typedef enum logic [1:0] {IDLE, REQ, KILL, HOLD} state_e;

  state_e            state_q, state_d;
  logic              imem_req_q, imem_req_d;
  logic [XLEN-1:0]   imem_addr_q, imem_addr_d;
  logic [ILEN-1:0]   inst_data_q, inst_data_d;
  logic [XLEN-1:0]   pc_out_q, pc_out_d;
  logic              inst_valid_q, inst_valid_d;
  logic [ILEN-1:0]   buf_data_q, buf_data_d;
  logic [XLEN-1:0]   buf_pc_q, buf_pc_d;
  logic [XLEN-1:0]   target_q, target_d;

  logic              deliver;
  logic [ILEN-1:0]   dlv_data;
  logic [XLEN-1:0]   dlv_pc;
  logic [XLEN-1:0]   redir_pc;
  logic [XLEN-1:0]   next_addr;

  assign redir_pc  = redirect_pc & ~XLEN'(3);
  assign next_addr = imem_addr_q + XLEN'(4);

  // Next-state, fetch request and decode-facing output logic
  always_comb begin
    state_d      = state_q;
    imem_req_d   = imem_req_q;
    imem_addr_d  = imem_addr_q;
    inst_data_d  = inst_data_q;
    pc_out_d     = pc_out_q;
    inst_valid_d = inst_valid_q;
    buf_data_d   = buf_data_q;
    buf_pc_d     = buf_pc_q;
    target_d     = target_q;
    deliver      = 1'b0;
    dlv_data     = imem_rdata;
    dlv_pc       = imem_addr_q;

    unique case (state_q)
      IDLE: begin
        imem_req_d = 1'b1;
        state_d    = REQ;
      end
      REQ: begin
        if (imem_ack) begin
          if (redirect) begin
            imem_addr_d = redir_pc;
          end else if (!stall) begin
            deliver     = 1'b1;
            imem_addr_d = next_addr;
          end else begin
            buf_data_d  = imem_rdata;
            buf_pc_d    = imem_addr_q;
            imem_req_d  = 1'b0;
            imem_addr_d = next_addr;
            state_d     = HOLD;
          end
        end else if (redirect) begin
          target_d = redir_pc;
          state_d  = KILL;
        end
      end
      KILL: begin
        // The in-flight response is dropped; the latest redirect target wins.
        if (redirect) target_d = redir_pc;
        if (imem_ack) begin
          imem_addr_d = redirect ? redir_pc : target_q;
          state_d     = REQ;
        end
      end
      HOLD: begin
        if (redirect) begin
          imem_addr_d = redir_pc;
          imem_req_d  = 1'b1;
          state_d     = REQ;
        end else if (!stall) begin
          deliver    = 1'b1;
          dlv_data   = buf_data_q;
          dlv_pc     = buf_pc_q;
          imem_req_d = 1'b1;
          state_d    = REQ;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Redirect flushes decode even under stall; stall otherwise freezes it.
    if (redirect) begin
      inst_data_d  = NOP_INST;
      inst_valid_d = 1'b0;
    end else if (!stall) begin
      if (deliver) begin
        inst_data_d  = dlv_data;
        pc_out_d     = dlv_pc;
        inst_valid_d = 1'b1;
      end else begin
        inst_data_d  = NOP_INST;
        inst_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      imem_req_q   <= 1'b0;
      imem_addr_q  <= RESET_PC;
      inst_data_q  <= NOP_INST;
      pc_out_q     <= '0;
      inst_valid_q <= 1'b0;
      buf_data_q   <= '0;
      buf_pc_q     <= '0;
      target_q     <= '0;
    end else begin
      state_q      <= state_d;
      imem_req_q   <= imem_req_d;
      imem_addr_q  <= imem_addr_d;
      inst_data_q  <= inst_data_d;
      pc_out_q     <= pc_out_d;
      inst_valid_q <= inst_valid_d;
      buf_data_q   <= buf_data_d;
      buf_pc_q     <= buf_pc_d;
      target_q     <= target_d;
    end
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = imem_addr_q;
  assign inst_data  = inst_data_q;
  assign pc_out     = pc_out_q;
  assign inst_valid = inst_valid_q;

endmodule

// File: tb/tb_riscv_zero_fetch.sv
// Bench for riscv_zero_fetch: directed plan scenarios plus random stall/redirect/ack
// traffic, checked every cycle against a transaction-level fetch model.
module tb_riscv_zero_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] inst_data;
  logic [63:0] pc_out;
  logic        inst_valid;

  // Second instance: wrap-around reset PC, zero-wait memory
  logic        req2;
  logic [63:0] addr2;
  logic [31:0] data2;
  logic [63:0] pc2;
  logic        valid2;
  logic        ack2;
  logic [31:0] rdata2;
  assign ack2   = req2;
  assign rdata2 = addr2[31:0] | 32'h13;

  riscv_zero_fetch dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst_data(inst_data),
    .pc_out(pc_out), .inst_valid(inst_valid)
  );

  riscv_zero_fetch #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_wrap (
    .clk(clk), .reset(reset), .stall(1'b0), .redirect(1'b0),
    .redirect_pc(64'h0), .imem_req(req2), .imem_addr(addr2),
    .imem_ack(ack2), .imem_rdata(rdata2), .inst_data(data2),
    .pc_out(pc2), .inst_valid(valid2)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Model: a fetch unit seen as "next PC", "one request in flight (maybe doomed)",
  // and "at most one parked instruction".
  bit          m_started;
  bit          m_req;
  logic [63:0] m_addr;
  logic [31:0] m_data;
  logic [63:0] m_pc;
  bit          m_valid;
  bit          m_doomed;
  logic [63:0] m_target;
  logic [31:0] m_park_data;
  logic [63:0] m_park_pc;

  task automatic model_reset();
    m_started = 0; m_req = 0; m_addr = 64'h0; m_data = NOP; m_pc = 64'h0;
    m_valid = 0; m_doomed = 0; m_target = 64'h0; m_park_data = '0; m_park_pc = '0;
  endtask

  task automatic model_step(input bit st, input bit rd, input logic [63:0] rpc,
                            input bit ak, input logic [31:0] dat);
    logic [63:0] tgt;
    bit          got;
    logic [31:0] g_data;
    logic [63:0] g_pc;
    tgt = {rpc[63:2], 2'b00};
    got = 0; g_data = '0; g_pc = '0;
    if (!m_started) begin
      m_started = 1; m_req = 1;
    end else if (m_req) begin
      if (ak) begin
        if (m_doomed || rd) begin
          m_addr = rd ? tgt : m_target;
          m_doomed = 0;
        end else if (!st) begin
          got = 1; g_data = dat; g_pc = m_addr; m_addr = m_addr + 64'd4;
        end else begin
          m_park_data = dat; m_park_pc = m_addr; m_addr = m_addr + 64'd4; m_req = 0;
        end
      end else if (rd) begin
        m_doomed = 1; m_target = tgt;
      end
    end else begin
      if (rd) begin
        m_addr = tgt; m_req = 1;
      end else if (!st) begin
        got = 1; g_data = m_park_data; g_pc = m_park_pc; m_req = 1;
      end
    end
    if (rd) begin
      m_data = NOP; m_valid = 0;
    end else if (!st) begin
      if (got) begin
        m_data = g_data; m_pc = g_pc; m_valid = 1;
      end else begin
        m_data = NOP; m_valid = 0;
      end
    end
  endtask

  // Drive one cycle's inputs, let the edge happen, then advance the model.
  task automatic cycle(input bit st, input bit rd, input logic [63:0] rpc,
                       input bit ak, input logic [31:0] dat);
    stall = st; redirect = rd; redirect_pc = rpc; imem_ack = ak; imem_rdata = dat;
    @(posedge clk);
    #1;
    model_step(st, rd, rpc, ak, dat);
  endtask

  task automatic zw();
    cycle(1'b0, 1'b0, 64'h0, m_req, m_addr[31:0] | 32'h13);
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("rst_req", {63'h0, imem_req}, 64'h0);
    chk("rst_data", {32'h0, inst_data}, {32'h0, NOP});
    chk("rst_valid", {63'h0, inst_valid}, 64'h0);
    chk("rst_pc", pc_out, 64'h0);
    chk("rst_addr", imem_addr, 64'h0);
    @(negedge clk);
    #1;
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_req", {63'h0, imem_req}, {63'h0, m_req});
      chk("cyc_addr", imem_addr, m_addr);
      chk("cyc_data", {32'h0, inst_data}, {32'h0, m_data});
      chk("cyc_pc", pc_out, m_pc);
      chk("cyc_valid", {63'h0, inst_valid}, {63'h0, m_valid});
    end
  end

  // Wrap-around instance: literal pc/address sequence across 2^64
  initial begin
    @(negedge reset);
    @(posedge clk); #1;
    chk("wrap_req0", {63'h0, req2}, 64'h1);
    chk("wrap_addr0", addr2, 64'hFFFF_FFFF_FFFF_FFFC);
    @(posedge clk); #1;
    chk("wrap_addr1", addr2, 64'h0);
    chk("wrap_pc1", pc2, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_data1", {32'h0, data2}, 64'hFFFF_FFFF);
    chk("wrap_valid1", {63'h0, valid2}, 64'h1);
    @(posedge clk); #1;
    chk("wrap_pc2", pc2, 64'h0);
    chk("wrap_data2", {32'h0, data2}, 64'h13);
    chk("wrap_addr2", addr2, 64'h4);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    @(negedge clk); #1;
    chk("init_req", {63'h0, imem_req}, 64'h0);
    chk("init_data", {32'h0, inst_data}, {32'h0, NOP});
    chk("init_addr", imem_addr, 64'h0);
    chk_en = 1'b1;
    reset  = 1'b0;

    // IDLE then zero-wait streaming
    cycle(0, 0, 64'h0, 0, 32'h0);
    chk("idle_req", {63'h0, imem_req}, 64'h1);
    chk("idle_valid", {63'h0, inst_valid}, 64'h0);
    zw();
    zw();
    chk("zw_addr", imem_addr, 64'h8);
    chk("zw_pc", pc_out, 64'h4);
    chk("zw_data", {32'h0, inst_data}, 64'h17);

    // Ack under stall parks the instruction
    cycle(1, 0, 64'h0, 1, 32'h0050_0093);
    chk("hold_req", {63'h0, imem_req}, 64'h0);
    chk("hold_data", {32'h0, inst_data}, 64'h17);
    cycle(1, 0, 64'h0, 1, 32'hFFFF_FFFF);
    chk("hold_frozen", {32'h0, inst_data}, 64'h17);
    cycle(0, 0, 64'h0, 0, 32'h0);
    chk("rel_data", {32'h0, inst_data}, 64'h0050_0093);
    chk("rel_pc", pc_out, 64'h8);
    chk("rel_valid", {63'h0, inst_valid}, 64'h1);
    chk("rel_addr", imem_addr, 64'hC);
    chk("rel_req", {63'h0, imem_req}, 64'h1);

    // Redirect while request outstanding
    zw();
    cycle(0, 1, 64'h203, 0, 32'h0);
    chk("kill_addr", imem_addr, 64'h10);
    chk("kill_valid", {63'h0, inst_valid}, 64'h0);
    cycle(0, 0, 64'h0, 0, 32'h0);
    chk("kill_addr2", imem_addr, 64'h10);
    cycle(0, 0, 64'h0, 1, 32'hDEAD_BEEF);
    chk("kill_next", imem_addr, 64'h200);
    chk("kill_drop", {63'h0, inst_valid}, 64'h0);

    // Redirect with ack, and under stall
    zw();
    cycle(1, 1, 64'h400, 1, 32'h1234_5678);
    chk("rda_addr", imem_addr, 64'h400);
    chk("rda_data", {32'h0, inst_data}, {32'h0, NOP});
    chk("rda_valid", {63'h0, inst_valid}, 64'h0);
    chk("rda_pc", pc_out, 64'h200);

    // Redirect from HOLD; double redirect in KILL
    zw();
    cycle(1, 0, 64'h0, 1, 32'h0000_CAFE);
    cycle(1, 1, 64'h81, 0, 32'h0);
    chk("hold_rd_addr", imem_addr, 64'h80);
    chk("hold_rd_req", {63'h0, imem_req}, 64'h1);
    cycle(0, 1, 64'h100, 0, 32'h0);
    cycle(0, 1, 64'h300, 1, 32'h0);
    chk("kill_win", imem_addr, 64'h300);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) do_reset();
      cycle(($urandom % 10) < 3, ($urandom % 10) == 0, {$urandom, $urandom},
            ($urandom % 10) < 6, $urandom);
    end

    // Reset while a redirect kill is pending
    cycle(0, 1, 64'h500, 0, 32'h0);
    do_reset();
    chk("pre_idle_req", {63'h0, imem_req}, 64'h0);
    cycle(0, 0, 64'h0, 0, 32'h0);
    chk("post_idle_req", {63'h0, imem_req}, 64'h1);
    chk("post_idle_addr", imem_addr, 64'h0);
    zw();
    zw();

    @(negedge clk);
    #1;
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
